// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: packs 6-bit pixels two per 16-bit RAM word via read-modify-write.
// Optional full-screen fill is compiled in with `define FB_FILL_EN.
module fb_pixel_writer #(
  parameter int unsigned MEM_WIDTH       = 256,
  parameter int unsigned MEM_HEIGHT      = 256,
  parameter int unsigned MEM_ADDR_OFFSET = 0
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [15:0] px_x,
  input  logic [15:0] px_y,
  input  logic [5:0]  px_color,
  input  logic        fill_start,
  input  logic [5:0]  fill_color,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  localparam logic [15:0] BASE_ADDR = 16'(MEM_ADDR_OFFSET);

`ifdef FB_FILL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, FILL = 2'd3} state_t;
  localparam int unsigned FILL_WORDS = MEM_WIDTH * MEM_HEIGHT / 2;
  localparam int unsigned CNT_W      = (FILL_WORDS > 1) ? $clog2(FILL_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FILL_WORDS - 1);
  logic [CNT_W-1:0] fill_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_t;
  logic unused_fill;
  assign unused_fill = &{1'b0, fill_start, fill_color};
`endif

  state_t      state;
  logic        lat_odd;
  logic [5:0]  lat_color;
  logic [15:0] wdata_q;
  logic        in_range;
  logic [31:0] lin_idx;

  // Replace one half of the word with the new pixel; padding bits are always cleared.
  function automatic logic [15:0] merge_pixel(input logic [15:0] rd, input logic odd,
                                              input logic [5:0] color);
    if (odd) merge_pixel = {2'b00, color, 2'b00, rd[5:0]};
    else     merge_pixel = {2'b00, rd[13:8], 2'b00, color};
  endfunction

  assign in_range = (32'(px_x) < MEM_WIDTH) && (32'(px_y) < MEM_HEIGHT);
  assign lin_idx  = (32'(px_y) * MEM_WIDTH + 32'(px_x)) >> 1;

`ifdef FB_FILL_EN
  assign px_ready = (state == IDLE) && !fill_start;
`else
  assign px_ready = (state == IDLE);
`endif

  // Read data arrives during WR, so the merged word is muxed straight onto the write bus.
  assign mem_wdata = (state == WR) ? merge_pixel(mem_rdata, lat_odd, lat_color) : wdata_q;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      wdata_q   <= '0;
      busy      <= 1'b0;
      lat_odd   <= 1'b0;
      lat_color <= '0;
`ifdef FB_FILL_EN
      fill_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
`ifdef FB_FILL_EN
          if (fill_start) begin
            state    <= FILL;
            busy     <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= BASE_ADDR;
            wdata_q  <= {2'b00, fill_color, 2'b00, fill_color};
            fill_cnt <= '0;
          end else
`endif
          if (px_valid && in_range) begin
            state     <= RD;
            busy      <= 1'b1;
            mem_addr  <= 16'(MEM_ADDR_OFFSET + lin_idx);
            lat_odd   <= px_x[0];
            lat_color <= px_color;
          end
        end
        RD: begin
          state  <= WR;
          mem_we <= 1'b1;
        end
        WR: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
`ifdef FB_FILL_EN
        FILL: begin
          if (fill_cnt == LAST_WORD) begin
            state  <= IDLE;
            mem_we <= 1'b0;
            busy   <= 1'b0;
          end else begin
            fill_cnt <= fill_cnt + CNT_W'(1);
            mem_addr <= mem_addr + 16'd1;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: a 256x256 instance for pixel writes and a 4x4 instance for fill.
module tb_fb_pixel_writer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear_n;

  logic        m_valid, m_fill_start;
  logic [15:0] m_x, m_y, m_rdata;
  logic [5:0]  m_color, m_fill_color;
  logic        m_ready, m_busy, m_we;
  logic [15:0] m_addr, m_wdata;

  logic        f_valid, f_fill_start;
  logic [15:0] f_x, f_y, f_rdata;
  logic [5:0]  f_color, f_fill_color;
  logic        f_ready, f_busy, f_we;
  logic [15:0] f_addr, f_wdata;

  fb_pixel_writer #(.MEM_WIDTH(256), .MEM_HEIGHT(256), .MEM_ADDR_OFFSET(0)) dut (
    .clock(clock), .clear_n(clear_n), .px_valid(m_valid), .px_ready(m_ready),
    .px_x(m_x), .px_y(m_y), .px_color(m_color), .fill_start(m_fill_start),
    .fill_color(m_fill_color), .busy(m_busy), .mem_addr(m_addr), .mem_wdata(m_wdata),
    .mem_we(m_we), .mem_rdata(m_rdata)
  );

  fb_pixel_writer #(.MEM_WIDTH(4), .MEM_HEIGHT(4), .MEM_ADDR_OFFSET(0)) dut_f (
    .clock(clock), .clear_n(clear_n), .px_valid(f_valid), .px_ready(f_ready),
    .px_x(f_x), .px_y(f_y), .px_color(f_color), .fill_start(f_fill_start),
    .fill_color(f_fill_color), .busy(f_busy), .mem_addr(f_addr), .mem_wdata(f_wdata),
    .mem_we(f_we), .mem_rdata(f_rdata)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [5:0]  color;
    logic [15:0] rdata;
    logic [15:0] addr;
    logic [15:0] wdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_pixel(input vec_t v);
    @(negedge clock);
    m_valid = 1'b1; m_x = v.x; m_y = v.y; m_color = v.color; m_rdata = v.rdata;
    chk("px_ready_before", 32'(m_ready), 1);
    @(posedge clock); #1;
    m_valid = 1'b0;
    @(negedge clock);
    chk("rd_addr", 32'(m_addr), 32'(v.addr));
    chk("rd_we", 32'(m_we), 0);
    chk("rd_ready", 32'(m_ready), 0);
    chk("rd_busy", 32'(m_busy), 1);
    @(negedge clock);
    chk("wr_we", 32'(m_we), 1);
    chk("wr_addr", 32'(m_addr), 32'(v.addr));
    chk("wr_wdata", 32'(m_wdata), 32'(v.wdata));
    @(negedge clock);
    chk("post_we", 32'(m_we), 0);
    chk("post_ready", 32'(m_ready), 1);
    chk("post_busy", 32'(m_busy), 0);
  endtask

  task automatic do_drop(input logic [15:0] x, input logic [15:0] y);
    @(negedge clock);
    m_valid = 1'b1; m_x = x; m_y = y; m_color = 6'h3F;
    chk("drop_ready_before", 32'(m_ready), 1);
    @(posedge clock); #1;
    m_valid = 1'b0;
    @(negedge clock);
    chk("drop_ready_next", 32'(m_ready), 1);
    chk("drop_we", 32'(m_we), 0);
    chk("drop_busy", 32'(m_busy), 0);
    @(negedge clock);
    chk("drop_we_later", 32'(m_we), 0);
  endtask

  task automatic chk_reset_main();
    chk("rst_we", 32'(m_we), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_wdata", 32'(m_wdata), 0);
    chk("rst_busy", 32'(m_busy), 0);
    chk("rst_ready", 32'(m_ready), 1);
  endtask

  task automatic chk_reset_fill();
    chk("frst_we", 32'(f_we), 0);
    chk("frst_addr", 32'(f_addr), 0);
    chk("frst_wdata", 32'(f_wdata), 0);
    chk("frst_busy", 32'(f_busy), 0);
    chk("frst_ready", 32'(f_ready), 1);
  endtask

  initial begin
    int acc;
    int strobes;

    vecs[0] = '{16'd4,   16'd1,   6'h2A, 16'h1500, 16'd130,   16'h152A};
    vecs[1] = '{16'd5,   16'd1,   6'h3F, 16'h152A, 16'd130,   16'h3F2A};
    vecs[2] = '{16'd5,   16'd1,   6'h00, 16'hFFFF, 16'd130,   16'h003F};
    vecs[3] = '{16'd0,   16'd0,   6'h15, 16'h0000, 16'd0,     16'h0015};
    vecs[4] = '{16'd255, 16'd255, 6'h3F, 16'h0000, 16'h7FFF,  16'h3F00};
    vecs[5] = '{16'd10,  16'd2,   6'h01, 16'hC0C0, 16'h0105,  16'h0001};
    vecs[6] = '{16'd3,   16'd100, 6'h2A, 16'h1234, 16'h3201,  16'h2A34};

    clear_n = 1'b0;
    m_valid = 1'b0; m_fill_start = 1'b0; m_x = '0; m_y = '0; m_color = '0;
    m_fill_color = '0; m_rdata = '0;
    f_valid = 1'b0; f_fill_start = 1'b0; f_x = '0; f_y = '0; f_color = '0;
    f_fill_color = '0; f_rdata = '0;

    repeat (2) @(negedge clock);
    chk_reset_main();
    chk_reset_fill();
    clear_n = 1'b1;

    for (int i = 0; i < 7; i++) do_pixel(vecs[i]);

    // Back-to-back pixels with valid held high
    @(negedge clock);
    acc = 0; strobes = 0;
    m_valid = 1'b1; m_x = 16'd8; m_y = 16'd0; m_color = 6'h11; m_rdata = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clock);
      chk("b2b_ready", 32'(m_ready), 32'(i % 3 == 0));
      if (m_we) strobes++;
      if (m_ready && m_valid) begin
        @(posedge clock); #1;
        acc++;
        if (acc == 4) m_valid = 1'b0;
        else m_x = 16'(8 + acc);
      end
    end
    chk("b2b_accepts", 32'(acc), 4);
    chk("b2b_strobes", 32'(strobes), 4);

    do_drop(16'd256, 16'd0);
    do_drop(16'd0, 16'd300);
    do_drop(16'hFFFF, 16'd5);

    // Reset asserted while the write strobe is active
    @(negedge clock);
    m_valid = 1'b1; m_x = 16'd4; m_y = 16'd1; m_color = 6'h2A; m_rdata = 16'h1500;
    @(posedge clock); #1;
    m_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("wr_we_before_rst", 32'(m_we), 1);
    clear_n = 1'b0;
    #1;
    chk_reset_main();
    @(negedge clock);
    clear_n = 1'b1;
    do_pixel(vecs[1]);

`ifdef FB_FILL_EN
    // Fill wins over a simultaneous pixel, which is then accepted afterwards
    @(negedge clock);
    f_fill_start = 1'b1; f_fill_color = 6'h15;
    f_valid = 1'b1; f_x = 16'd1; f_y = 16'd1; f_color = 6'h2A; f_rdata = 16'h0000;
    chk("fill_blocks_ready", 32'(f_ready), 0);
    @(posedge clock); #1;
    f_fill_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("fill_we", 32'(f_we), 1);
      chk("fill_addr", 32'(f_addr), 32'(i));
      chk("fill_wdata", 32'(f_wdata), 32'h1515);
      chk("fill_busy", 32'(f_busy), 1);
      chk("fill_ready", 32'(f_ready), 0);
    end
    @(negedge clock);
    chk("fill_done_busy", 32'(f_busy), 0);
    chk("fill_done_we", 32'(f_we), 0);
    chk("fill_done_ready", 32'(f_ready), 1);
    @(posedge clock); #1;
    f_valid = 1'b0;
    @(negedge clock);
    chk("held_px_rd_addr", 32'(f_addr), 2);
    chk("held_px_rd_we", 32'(f_we), 0);
    @(negedge clock);
    chk("held_px_wr_we", 32'(f_we), 1);
    chk("held_px_wdata", 32'(f_wdata), 32'h2A00);

    // Reset asserted mid-fill
    @(negedge clock);
    f_fill_start = 1'b1; f_fill_color = 6'h3F;
    @(posedge clock); #1;
    f_fill_start = 1'b0;
    repeat (3) @(negedge clock);
    chk("midfill_we", 32'(f_we), 1);
    chk("midfill_addr", 32'(f_addr), 2);
    clear_n = 1'b0;
    #1;
    chk_reset_fill();
    @(negedge clock);
    clear_n = 1'b1;
`else
    // Without fill support fill_start must not block or start anything
    @(negedge clock);
    f_fill_start = 1'b1; f_fill_color = 6'h15;
    f_valid = 1'b1; f_x = 16'd1; f_y = 16'd1; f_color = 6'h2A; f_rdata = 16'h0000;
    chk("nofill_ready", 32'(f_ready), 1);
    @(posedge clock); #1;
    f_fill_start = 1'b0; f_valid = 1'b0;
    @(negedge clock);
    chk("nofill_rd_addr", 32'(f_addr), 2);
    chk("nofill_rd_we", 32'(f_we), 0);
    @(negedge clock);
    chk("nofill_wr_we", 32'(f_we), 1);
    chk("nofill_wdata", 32'(f_wdata), 32'h2A00);
    @(negedge clock);
    chk("nofill_idle_busy", 32'(f_busy), 0);
`endif

    // Normal pixel on the small instance after the preceding sequence
    @(negedge clock);
    f_valid = 1'b1; f_x = 16'd2; f_y = 16'd3; f_color = 6'h15; f_rdata = 16'h0000;
    chk("small_px_ready", 32'(f_ready), 1);
    @(posedge clock); #1;
    f_valid = 1'b0;
    @(negedge clock);
    chk("small_rd_addr", 32'(f_addr), 7);
    chk("small_rd_we", 32'(f_we), 0);
    @(negedge clock);
    chk("small_wr_we", 32'(f_we), 1);
    chk("small_wdata", 32'(f_wdata), 32'h0015);
    @(negedge clock);
    chk("small_post_we", 32'(f_we), 0);
    chk("small_post_ready", 32'(f_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
